// File: rtl/sysram_arb_pkg.sv
// Shared definitions for the system-RAM write arbiter: FSM encoding, default widths
// and the RAM map locations the producers write to.
package sysram_arb_pkg;

  localparam int DEF_AW = 10;
  localparam int DEF_DW = 32;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam logic [9:0] RAM_STATUS_BASE  = 10'h200;
  localparam logic [9:0] RAM_DNA_LO       = 10'h206;
  localparam logic [9:0] RAM_DNA_HI       = 10'h207;
  localparam logic [9:0] RAM_ALARMS       = 10'h209;
  localparam logic [9:0] RAM_XADC_FIRST   = 10'h20a;
  localparam logic [9:0] RAM_XADC_LAST    = 10'h20c;
  localparam logic [9:0] RAM_COIN_STATUS  = 10'h20d;
  localparam logic [9:0] RAM_GOLDEN_NONCE = 10'h20e;

endpackage

// File: rtl/sysram_wr_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant of the first request found at or above ptr,
// wrapping past the top index back to zero.
module rr_pick
  import sysram_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < N; off++) begin
      idx = IW'((int'(ptr) + off) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sysram_wr_arbiter.sv
// Single-port system-RAM write arbiter: host stream (0) first with burst locking, others
// round-robin with starvation guard. Define SYSRAM_ARB_STATS_EN for the stat_word counters.
module sysram_wr_arbiter
  import sysram_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MAX_WAIT = 64,
  parameter int LOCK_MAX = 32
) (
  input  logic               clk_100,
  input  logic               rst_100,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_lock,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
`ifdef SYSRAM_ARB_STATS_EN
  input  logic               stat_clr,
  output logic [31:0]        stat_word,
`endif
  output logic               system_ram_we_100,
  output logic [AW-1:0]      system_ram_addr_100,
  output logic [DW-1:0]      data_to_systemram_100,
  output logic [2:0]         gnt_id,
  output logic               locked
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(LOCK_MAX + 1);
  localparam int CW = 8;

  arb_state_t      state;
  logic [IW-1:0]   owner, rr_ptr, pen_id, xfer_id;
  logic            pen, inv_seen, xfer, forced_rel;
  logic [BW-1:0]   beat_cnt, beat_next;
  logic [CW-1:0]   wait_cnt [NREQ];
  logic [NREQ-1:0] urgent, eligible, pen_onehot, owner_onehot;
  logic [NREQ-1:0] rr_req, rr_gnt, urgent_e, arb_gnt;

  always_comb begin
    for (int i = 0; i < NREQ; i++)
      urgent[i] = req_valid[i] && (wait_cnt[i] == CW'(MAX_WAIT));
  end

  assign pen_onehot   = NREQ'(1) << pen_id;
  assign owner_onehot = NREQ'(1) << owner;

  // After a forced release the old owner sits out one arbitration if anyone else wants it.
  always_comb begin
    eligible = req_valid;
    if (pen && ((req_valid & ~pen_onehot) != '0))
      eligible = req_valid & ~pen_onehot;
  end

  assign urgent_e = eligible & urgent;
  assign rr_req   = eligible & ~NREQ'(1);

  rr_pick #(.N(NREQ), .IW(IW)) u_rr_pick (
    .req (rr_req),
    .ptr (rr_ptr),
    .gnt (rr_gnt)
  );

  always_comb begin
    if (urgent_e != '0)
      arb_gnt = urgent_e & (~urgent_e + NREQ'(1));
    else if (eligible[0])
      arb_gnt = NREQ'(1);
    else
      arb_gnt = rr_gnt;
  end

  always_comb begin
    if (rst_100)
      req_ready = '0;
    else if (state == LOCKED)
      req_ready = req_valid & owner_onehot;
    else
      req_ready = arb_gnt;
  end

  always_comb begin
    xfer_id = '0;
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i]) xfer_id = IW'(i);
  end

  assign xfer       = |req_ready;
  assign beat_next  = beat_cnt + BW'(xfer);
  assign forced_rel = (state == LOCKED) && (beat_next >= BW'(LOCK_MAX));

  always_ff @(posedge clk_100) begin
    if (rst_100) begin
      state                 <= ARB;
      owner                 <= '0;
      rr_ptr                <= IW'(1);
      pen                   <= 1'b0;
      pen_id                <= '0;
      inv_seen              <= 1'b0;
      beat_cnt              <= '0;
      locked                <= 1'b0;
      system_ram_we_100     <= 1'b0;
      system_ram_addr_100   <= '0;
      data_to_systemram_100 <= '0;
      gnt_id                <= '0;
      for (int i = 0; i < NREQ; i++) wait_cnt[i] <= '0;
    end else begin
      system_ram_we_100 <= xfer;
      if (xfer) begin
        system_ram_addr_100   <= req_addr[xfer_id*AW +: AW];
        data_to_systemram_100 <= req_data[xfer_id*DW +: DW];
        gnt_id                <= 3'(xfer_id);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || req_ready[i])
          wait_cnt[i] <= '0;
        else if (wait_cnt[i] != CW'(MAX_WAIT))
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
      if (xfer && xfer_id != '0)
        rr_ptr <= (xfer_id == IW'(NREQ - 1)) ? IW'(1) : xfer_id + IW'(1);
      case (state)
        ARB: begin
          if (xfer) begin
            pen <= 1'b0;
            if (req_lock[xfer_id]) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              owner    <= xfer_id;
              beat_cnt <= BW'(1);
              inv_seen <= 1'b0;
            end
          end
        end
        LOCKED: begin
          beat_cnt <= beat_next;
          inv_seen <= !req_valid[owner];
          // Beat limit wins over the other release reasons so the penalty is always applied.
          if (forced_rel) begin
            state  <= ARB;
            locked <= 1'b0;
            pen    <= 1'b1;
            pen_id <= owner;
          end else if (!req_lock[owner] || (inv_seen && !req_valid[owner])) begin
            state  <= ARB;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= ARB;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef SYSRAM_ARB_STATS_EN
  logic [15:0] stat_writes;
  logic [7:0]  stat_urgent, stat_forced;

  always_ff @(posedge clk_100) begin
    if (rst_100 || stat_clr) begin
      stat_writes <= '0;
      stat_urgent <= '0;
      stat_forced <= '0;
    end else begin
      if (xfer && stat_writes != 16'hFFFF)
        stat_writes <= stat_writes + 16'd1;
      if (xfer && state == ARB && urgent_e != '0 && stat_urgent != 8'hFF)
        stat_urgent <= stat_urgent + 8'd1;
      if (forced_rel && stat_forced != 8'hFF)
        stat_forced <= stat_forced + 8'd1;
    end
  end

  assign stat_word = {stat_writes, stat_urgent, stat_forced};
`endif

endmodule

// File: tb/tb_sysram_wr_arbiter.sv
// Bench for sysram_wr_arbiter: directed scenarios plus randomized traffic checked against
// a rule-level model. Also covers stat_word when SYSRAM_ARB_STATS_EN is defined.
module tb_sysram_wr_arbiter;
  import sysram_arb_pkg::*;

  localparam int NREQ     = 4;
  localparam int AW       = 10;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 64;
  localparam int LOCK_MAX = 32;

  logic               clk_100 = 1'b0;
  logic               rst_100;
  logic [NREQ-1:0]    req_valid, req_lock, req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               system_ram_we_100;
  logic [AW-1:0]      system_ram_addr_100;
  logic [DW-1:0]      data_to_systemram_100;
  logic [2:0]         gnt_id;
  logic               locked;
`ifdef SYSRAM_ARB_STATS_EN
  logic               stat_clr;
  logic [31:0]        stat_word;
`endif

  always #5 clk_100 = ~clk_100;

  sysram_wr_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk_100               (clk_100),
    .rst_100               (rst_100),
    .req_valid             (req_valid),
    .req_lock              (req_lock),
    .req_addr              (req_addr),
    .req_data              (req_data),
    .req_ready             (req_ready),
`ifdef SYSRAM_ARB_STATS_EN
    .stat_clr              (stat_clr),
    .stat_word             (stat_word),
`endif
    .system_ram_we_100     (system_ram_we_100),
    .system_ram_addr_100   (system_ram_addr_100),
    .data_to_systemram_100 (data_to_systemram_100),
    .gnt_id                (gnt_id),
    .locked                (locked)
  );

  int test_count = 0;
  int fail_count = 0;

  int          m_wait [NREQ];
  int          m_ptr, m_owner, m_beats, m_inv, m_pen_id, m_gnt;
  bit          m_locked, m_pen, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  logic [NREQ-1:0] last_ready;
  logic            last_we, last_locked;

  function automatic void modelReset();
    for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
    m_ptr = 1; m_owner = 0; m_beats = 0; m_inv = 0; m_pen_id = 0; m_gnt = 0;
    m_locked = 0; m_pen = 0; m_we = 0; m_addr = '0; m_data = '0;
  endfunction

  // Which requester the rules say is accepted this cycle, -1 for none.
  function automatic int modelPick();
    bit elig [NREQ];
    bit others;
    if (rst_100) return -1;
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    others = 0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i];
      if (m_pen && i != m_pen_id && req_valid[i]) others = 1;
    end
    if (m_pen && others) elig[m_pen_id] = 0;
    for (int i = 0; i < NREQ; i++)
      if (elig[i] && m_wait[i] == MAX_WAIT) return i;
    if (elig[0]) return 0;
    for (int off = 0; off < NREQ - 1; off++) begin
      int j;
      j = 1 + ((m_ptr - 1 + off) % (NREQ - 1));
      if (elig[j]) return j;
    end
    return -1;
  endfunction

  function automatic void modelStep(int g);
    int inv_next;
    if (rst_100) begin
      modelReset();
      return;
    end
    m_we = (g >= 0);
    if (g >= 0) begin
      m_addr = req_addr[g*AW +: AW];
      m_data = req_data[g*DW +: DW];
      m_gnt  = g;
    end
    for (int i = 0; i < NREQ; i++)
      m_wait[i] = (!req_valid[i] || i == g) ? 0 :
                  ((m_wait[i] + 1 > MAX_WAIT) ? MAX_WAIT : m_wait[i] + 1);
    if (g >= 1) m_ptr = (g == NREQ - 1) ? 1 : g + 1;
    if (!m_locked) begin
      if (g >= 0) begin
        m_pen = 0;
        if (req_lock[g]) begin
          m_locked = 1; m_owner = g; m_beats = 1; m_inv = 0;
        end
      end
    end else begin
      if (g == m_owner) m_beats++;
      inv_next = req_valid[m_owner] ? 0 : m_inv + 1;
      if (m_beats >= LOCK_MAX) begin
        m_locked = 0; m_pen = 1; m_pen_id = m_owner;
      end else if (!req_lock[m_owner] || inv_next >= 2) begin
        m_locked = 0;
      end
      m_inv = inv_next;
    end
  endfunction

  function automatic int grantOf(logic [NREQ-1:0] r);
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
    test_count++;
    assert (obs === exp)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(int g);
    logic [NREQ-1:0] exp_ready;
    exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
    checkVal("req_ready", 32'(req_ready), 32'(exp_ready));
    checkVal("we", 32'(system_ram_we_100), 32'(m_we));
    checkVal("addr", 32'(system_ram_addr_100), 32'(m_addr));
    checkVal("data", data_to_systemram_100, m_data);
    if (m_we) checkVal("gnt_id", 32'(gnt_id), 32'(m_gnt));
    checkVal("locked", 32'(locked), 32'(m_locked));
  endtask

  task automatic applyStimulus(logic [NREQ-1:0] v, logic [NREQ-1:0] l, logic r);
    req_valid = v;
    req_lock  = l;
    rst_100   = r;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = AW'($urandom);
      req_data[i*DW +: DW] = $urandom;
    end
  endtask

  task automatic runCycle();
    int g;
    #4;
    g = modelPick();
    checkOutput(g);
    last_ready  = req_ready;
    last_we     = system_ram_we_100;
    last_locked = locked;
    modelStep(g);
    @(posedge clk_100);
    #1;
  endtask

  task automatic doReset();
    applyStimulus('0, '0, 1'b1);
    runCycle();
    applyStimulus('0, '0, 1'b0);
  endtask

  initial begin
    int seq [$];
    int exp_rr [6];
    int pos1, nxt, when;
    logic [NREQ-1:0] v, l;

    exp_rr = '{1, 2, 3, 1, 2, 3};
`ifdef SYSRAM_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    applyStimulus('0, '0, 1'b1);
    modelReset();
    @(posedge clk_100);
    #1;

    // Single request lands on the RAM port one cycle later.
    doReset();
    applyStimulus(4'b0100, '0, 1'b0);
    req_addr[2*AW +: AW] = RAM_COIN_STATUS;
    req_data[2*DW +: DW] = 32'hDEADBEEF;
    runCycle();
    checkVal("single_ready", 32'(last_ready), 32'h4);
    applyStimulus('0, '0, 1'b0);
    runCycle();
    checkVal("single_we", 32'(last_we), 32'h1);
    checkVal("single_addr", 32'(system_ram_addr_100), 32'(RAM_COIN_STATUS));
    checkVal("single_data", data_to_systemram_100, 32'hDEADBEEF);
    checkVal("single_gnt", 32'(gnt_id), 32'd2);

    // Round-robin among 1..3.
    doReset();
    applyStimulus(4'b1110, '0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      runCycle();
      checkVal("rr_order", 32'(grantOf(last_ready)), 32'(exp_rr[c]));
    end

    // Locked burst from the host is cut at the beat limit and yields once.
    doReset();
    applyStimulus(4'b0011, 4'b0001, 1'b0);
    seq.delete();
    for (int c = 0; c < 40; c++) begin
      runCycle();
      seq.push_back(grantOf(last_ready));
      if (last_ready[1]) req_valid[1] = 1'b0;
    end
    pos1 = -1;
    foreach (seq[k]) if (seq[k] == 1 && pos1 < 0) pos1 = k;
    nxt = (pos1 >= 0 && pos1 + 1 < seq.size()) ? seq[pos1 + 1] : -1;
    checkVal("burst_len", 32'(pos1), 32'd32);
    checkVal("burst_resume", 32'(nxt), 32'd0);

    // Starving requester becomes urgent and wins over the host.
    doReset();
    applyStimulus(4'b1001, '0, 1'b0);
    when = -1;
    for (int c = 1; c <= 100 && when < 0; c++) begin
      runCycle();
      if (last_ready[3]) when = c;
    end
    checkVal("urgent_cycle", 32'(when), 32'd65);
    runCycle();
    checkVal("after_urgent", 32'(grantOf(last_ready)), 32'd0);

    // Reset in the middle of a locked burst.
    doReset();
    applyStimulus(4'b0100, '0, 1'b0);
    runCycle();
    applyStimulus(4'b0001, 4'b0001, 1'b0);
    for (int c = 0; c < 3; c++) runCycle();
    applyStimulus(4'b0001, 4'b0001, 1'b1);
    runCycle();
    checkVal("rst_ready", 32'(last_ready), 32'h0);
    applyStimulus(4'b1110, '0, 1'b0);
    runCycle();
    checkVal("rst_we", 32'(last_we), 32'h0);
    checkVal("rst_locked", 32'(last_locked), 32'h0);
    checkVal("rst_ptr", 32'(grantOf(last_ready)), 32'd1);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      v = NREQ'($urandom | $urandom);
      l = NREQ'($urandom | $urandom);
      applyStimulus(v, l, ($urandom_range(0, 79) == 0));
      runCycle();
    end

`ifdef SYSRAM_ARB_STATS_EN
    doReset();
    applyStimulus(4'b0100, '0, 1'b0);
    for (int c = 0; c < 5; c++) runCycle();
    applyStimulus(4'b0001, 4'b0001, 1'b0);
    for (int c = 0; c < LOCK_MAX; c++) runCycle();
    applyStimulus('0, '0, 1'b0);
    checkVal("stat_word", stat_word, {16'd37, 8'd0, 8'd1});
    stat_clr = 1'b1;
    runCycle();
    stat_clr = 1'b0;
    checkVal("stat_clr", stat_word, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/sysram_wr_arbiter.md
Name: sysram_wr_arbiter

Overview:
- Arbitrates the single system-RAM write port (we/addr/data, 10-bit word address, 32-bit data) between several producers in the clk_100 domain.
- Producers are the host-download stream, status/DNA words, XADC readings and mining results.
- Requester 0 is the host stream: highest priority, with burst locking.
- Requesters 1..NREQ-1 are served round-robin, with starvation protection.
- Output is registered and drives the RAM write port directly.

Parameters:
- NREQ, 4, number of requesters (2..8); index 0 = host stream.
- AW, 10, RAM word-address width.
- DW, 32, RAM data width.
- MAX_WAIT, 64, cycles a valid requester may wait before it becomes urgent (1..255).
- LOCK_MAX, 32, maximum beats in one locked burst before forced release.

Ports:
- clk_100  in  1  system clock.
- rst_100  in  1  reset; synchronous and active-high.
- req_valid  in  NREQ  write request per requester.
- req_lock  in  NREQ  hold the grant across consecutive beats (burst).
- req_addr  in  NREQ*AW  packed addresses; requester i occupies [i*AW +: AW].
- req_data  in  NREQ*DW  packed data; requester i occupies [i*DW +: DW].
- req_ready  out  NREQ  one-hot-or-zero accept strobe, combinational from registered state and req_valid.
- system_ram_we_100  out  1  RAM write enable.
- system_ram_addr_100  out  AW  RAM address.
- data_to_systemram_100  out  DW  RAM data.
- gnt_id  out  3  index of the requester written in the current output cycle.
- locked  out  1  a burst lock is currently held.

Behaviour:
- Reset (rst_100 high at a clock edge):
  - we=0, addr=0, data=0, gnt_id=0, locked=0.
  - Round-robin pointer = 1; all wait counters = 0; beat counter = 0; FSM = ARB.
  - req_ready is forced to 0 while rst_100 is high.
- Transfer rules:
  - A transfer occurs when req_valid[i] & req_ready[i].
  - At most one req_ready bit is high per cycle.
  - The accepted addr/data appear on the RAM port the next cycle with we=1 and gnt_id=i (latency 1).
  - we=0 in any cycle following no transfer; addr and data then hold their last values.
- Arbitration order in ARB state, highest first:
  1. Urgent requesters, lowest index first.
  2. Requester 0.
  3. Requesters 1..NREQ-1 round-robin, searching from the pointer upward and wrapping past NREQ-1 back to 1.
- Pointer update: after a grant to requester k≥1, the pointer becomes k+1, wrapping to 1 after NREQ-1. A grant to requester 0 leaves the pointer unchanged.
- Wait counters (one per requester):
  - Increment while valid and not granted; saturate at MAX_WAIT.
  - Urgent = counter==MAX_WAIT.
  - Clear on a transfer, or when valid is low.
- FSM states: ARB, LOCKED.
  - ARB→LOCKED: on a transfer from requester i with req_lock[i]=1. The owner is recorded and the beat counter is set to 1.
  - While LOCKED: only the owner can receive ready. Urgent requesters do NOT preempt. Each owner transfer increments the beat counter.
  - LOCKED→ARB when any of these holds:
    - req_lock[owner]=0, checked at the cycle boundary.
    - req_valid[owner]=0 for 2 consecutive cycles.
    - The beat counter reaches LOCK_MAX. The owner then loses the next arbitration to any other valid requester, for one arbitration only.
  - locked = 1 while in LOCKED.
- Simultaneous events:
  - A lock release and a new request in the same cycle: arbitration runs normally in the following cycle. There are no idle cycles beyond the one-cycle state change.
  - Several requesters urgent at once: lowest index wins.
- Reset mid-burst: any accepted beat is still in the output register; reset clears it (we=0) and the beat is lost. This is documented, not protected.
- The arbiter does not check addresses; it has no FIFO and no backpressure beyond req_ready.

Optional Feature:
- Macro: SYSRAM_ARB_STATS_EN.
- When defined:
  - Adds output stat_word (32 bits): {16-bit total write count, 8-bit urgent-event count, 8-bit forced-release count}.
  - All three counters saturate and clear on rst_100.
  - Adds input stat_clr (1 bit); stat_clr high at an edge clears all three counters the same cycle, and takes priority over increments.
- When undefined: neither port exists and no counter logic is built.
- Arbitration behaviour is identical in both builds.

Decomposition:
- Package sysram_arb_pkg:
  - FSM state encoding ARB=1'b0, LOCKED=1'b1.
  - Default AW/DW.
  - RAM map constants used by requesters: status base 10'h200, DNA 10'h206/10'h207, alarms 10'h209, XADC 10'h20a..10'h20c, coin status 10'h20d, golden nonce 10'h20e.
- One sub-module, rr_pick: given a request vector and a pointer, returns the one-hot grant with wrap-around. Used for the round-robin stage.

Test Plan:
- Reset, then requester 2 valid with addr 10'h20d, data 32'hDEADBEEF → req_ready[2]=1 that cycle; next cycle we=1, addr=10'h20d, data=32'hDEADBEEF, gnt_id=2.
- Requesters 1, 2, 3 all valid continuously → grants in order 1, 2, 3, 1, 2, 3; each req_ready pulse is one cycle.
- Requester 0 valid with lock for 40 beats while requester 1 waits → 32 beats to requester 0, forced release, one beat to requester 1, then requester 0 resumes.
- Requester 0 valid without lock continuously, requester 3 valid → requester 3 becomes urgent after 64 cycles, is granted on cycle 65, then requester 0 continues.
- rst_100 asserted mid-burst (LOCKED) → next cycle we=0 and locked=0, all req_ready=0 while reset is high, and the pointer is back at 1 after release.
- With SYSRAM_ARB_STATS_EN: 5 writes, then a forced release → stat_word[31:16]=5 plus the burst beats, forced-release field=1; stat_clr → stat_word=0 the next cycle.
